// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit.
// Holds the FSM state type, the supported opcodes, the ALUOp and
// ALUControl codes, and the select encodings for ResultSrc, ALUSrcA,
// ALUSrcB and ImmSrc. No ports.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_if.sv
// Bundle between the multicycle datapath and its control unit.
// Datapath -> control: op, funct3, funct7b5 (instruction fields), Zero.
// Control -> datapath: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
// ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, IllegalOp.
// master = datapath side, slave = control unit side.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       IllegalOp;

  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, IllegalOp
  );

  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, IllegalOp
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode, purely combinational.
// Ports: alu_op_i (00 add, 01 sub, 10 from funct), funct3_i, funct7b5_i,
// op5_i (op[5], distinguishes R-type from I-type), alu_control_o.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALUCTL_ADD;
    unique case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALUCTL_ADD;
      ALUOP_SUB: alu_control_o = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type has a sub; addi with Instr[30]=1 is still an add.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control_o = ALUCTL_SLT;
          3'b110:  alu_control_o = ALUCTL_OR;
          3'b111:  alu_control_o = ALUCTL_AND;
          default: alu_control_o = ALUCTL_ADD;
        endcase
      end
      default: alu_control_o = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control unit of the RV32I multicycle core (lw, sw, R/I ALU, beq, jal).
// Moore FSM driving all datapath selects and enables, plus the ALU and
// immediate-format decode.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// mc_controller_if: instruction fields and Zero in, control signals out).
module mc_controller
  import riscv_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  mc_controller_if.slave bus
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal_op;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_WD;

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut: the beq target used later in BEQ.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_A;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_A;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // During reset present FETCH selects with every write enable held off,
    // so an instruction aborted mid-flight cannot commit anything.
    if (reset) begin
      alu_op     = ALUOP_ADD;
      branch     = 1'b0;
      pc_update  = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      result_src = RES_ALURESULT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .op5_i         (bus.op[5]),
    .alu_control_o (alu_control)
  );

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  assign bus.PCWrite    = (branch & bus.Zero) | pc_update;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.RegWrite   = reg_write;
  assign bus.IllegalOp  = illegal_op;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mc_controller_if bus_if ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB
  //              ALUControl ImmSrc RegWrite IllegalOp
  function automatic logic [16:0] e(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] ac, input logic [1:0] imm,
                                    input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus_if.PCWrite, bus_if.AdrSrc, bus_if.MemWrite, bus_if.IRWrite,
            bus_if.ResultSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUControl,
            bus_if.ImmSrc, bus_if.RegWrite, bus_if.IllegalOp};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bus_if.op       = o;
    bus_if.funct3   = f3;
    bus_if.funct7b5 = f7;
    #1;
  endtask

  // FETCH and DECODE look the same for every instruction apart from ImmSrc.
  task automatic fetch_decode(input string name, input logic [1:0] imm);
    chk({name, "_fetch"},  e(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0));
    step();
    chk({name, "_decode"}, e(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0));
    step();
  endtask

  // R-type / I-type: FETCH, DECODE, EXECUTE, ALUWB, back to FETCH.
  task automatic run_alu(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [1:0] exp_sb, input logic [2:0] exp_ac);
    set_instr(o, f3, f7);
    fetch_decode(name, 2'b00);
    chk({name, "_exec"},  e(0, 0, 0, 0, 2'b00, 2'b10, exp_sb, exp_ac, 2'b00, 0, 0));
    step();
    chk({name, "_aluwb"}, e(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus_if.Zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);

    // Reset held two cycles: FETCH selects, enables off.
    step();
    chk("reset_c1", e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    step();
    chk("reset_c2", e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    reset = 1'b0;
    #1;

    // lw: 5 cycles
    fetch_decode("lw", 2'b00);
    chk("lw_memadr",  e(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    step();
    chk("lw_memread", e(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    step();
    chk("lw_memwb",   e(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    step();

    // sw: 4 cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_decode("sw", 2'b01);
    chk("sw_memadr",   e(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    step();
    chk("sw_memwrite", e(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    step();

    // ALU decode variants
    run_alu("sub",      7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
    run_alu("add",      7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
    run_alu("addi_f7",  7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
    run_alu("slt",      7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
    run_alu("or",       7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);
    run_alu("andi",     7'b0010011, 3'b111, 1'b0, 2'b01, 3'b010);
    run_alu("xor_dflt", 7'b0110011, 3'b100, 1'b0, 2'b00, 3'b000);

    // beq: 3 cycles, PCWrite follows Zero inside BEQ
    set_instr(7'b1100011, 3'b000, 1'b0);
    fetch_decode("beq", 2'b10);
    bus_if.Zero = 1'b1;
    #1;
    chk("beq_taken",    e(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
    bus_if.Zero = 1'b0;
    #1;
    chk("beq_nottaken", e(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
    step();

    // jal: 4 cycles
    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_decode("jal", 2'b11);
    chk("jal_jal",   e(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
    step();
    chk("jal_aluwb", e(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0));
    step();

    // Illegal opcode: 2 cycles, IllegalOp in DECODE
    set_instr(7'b1111111, 3'b000, 1'b0);
    chk("ill_fetch",  e(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    step();
    chk("ill_decode", e(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
    step();

    // Reset during MEMWRITE aborts the store
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_decode("swr", 2'b01);
    step();
    chk("swr_memwrite", e(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    reset = 1'b1;
    #1;
    chk("swr_reset_mw", e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));
    step();
    chk("swr_reset_c2", e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));
    reset = 1'b0;
    #1;
    chk("swr_refetch",  e(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));
    step();
    chk("swr_redecode", e(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Main control unit for the RV32I multicycle core. A Moore state machine, plus combinational ALU and immediate decode, drives every select and write-enable of the multicycle datapath. It fetches, decodes and executes one instruction at a time. The supported subset is lw, sw, R-type ALU, I-type ALU, beq and jal.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; state register returns to FETCH on the next edge
- op  input  7  Instr[6:0] from instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  output  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file write enable
- IllegalOp  output  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Internal signals: ALUOp (00 add, 01 sub, 10 funct), Branch, PCUpdate.
- PCWrite = (Branch & Zero) | PCUpdate.
- Any signal not listed for a state is 0. Selects not listed are 00.
- Per-state outputs:
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. This precomputes the branch target into ALUOut.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other op → FETCH with IllegalOp = 1.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI and JAL → ALUWB → FETCH.
  - BEQ → FETCH.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by funct3: 000 → sub if op[5] & funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add.
  - An I-type instruction with funct7b5 = 1 is still add (op[5] = 0).
- ImmSrc is decoded combinationally from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.

## Timing
- State register updates on the rising clk edge. Next state is FETCH whenever reset is high at the edge.
- Outputs are Moore (state only), except:
  - PCWrite is also a function of Zero.
  - ALUControl is also a function of funct3, funct7b5 and op.
  - ImmSrc is a function of op.
  - IllegalOp is a function of state and op.
- While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 regardless of state.
- Output values with reset held high: all write enables 0, IllegalOp 0, all other outputs at their FETCH values.
- The first FETCH write-enables appear in the first cycle after reset deasserts.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type and I-type 4
  - jal 4
  - beq 3
  - illegal opcode 2
- beq taken: PC is loaded from ALUOut (the target computed in DECODE) at the end of BEQ, only if Zero = 1 in that cycle.
- Reset asserted mid-instruction: the state aborts to FETCH, and any MemWrite or RegWrite pending in that cycle is suppressed.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum type (11 states);
  - opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp and ALUControl encodings;
  - ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module `alu_decoder` takes ALUOp, funct3, funct7b5 and op[5] and produces ALUControl; it is purely combinational.
- The main FSM and the ImmSrc decode stay in `mc_controller`.

## Test plan
- Reset: hold reset 2 cycles. Required: all write enables 0 and IllegalOp 0 while reset is high; in the first cycle after release, state is FETCH with IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10.
- lw (op 0000011): required state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite = 1 only in MEMWB, with ResultSrc = 01 there; AdrSrc = 1 in MEMREAD; ImmSrc = 00.
- sw: required sequence FETCH, DECODE, MEMADR, MEMWRITE, taking 4 cycles. MemWrite = 1 only in MEMWRITE; ImmSrc = 01.
- R-type sub (funct3 000, funct7b5 1): ALUControl = 001 in EXECUTER, with RegWrite in ALUWB. addi with funct7b5 = 1: ALUControl = 000. slt gives 101, or gives 011, and gives 010.
- beq: with Zero = 1 in BEQ, PCWrite = 1 that cycle. With Zero = 0, PCWrite = 0. Either way the next state is FETCH, 3 cycles total.
- Illegal op 1111111: IllegalOp pulses 1 cycle in DECODE and the next state is FETCH. Separately, asserting reset during MEMWRITE drops MemWrite to 0 in that cycle, and the FSM is in FETCH at the following edge.
